// File: rtl/pixel_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_collector
// Purpose  : Tags decoded bus words with frame/row position, queues them in a
//            first-word-fall-through FIFO and streams them out over READY/VALID,
//            draining each frame completely before the next one is armed.
// Revision : 1.0
// ============================================================================
module pixel_stream_collector #(
    parameter int PIXEL_ARRAY_WIDTH  = 4,
    parameter int PIXEL_ARRAY_HEIGHT = 4,
    parameter int OUTPUT_BUS_WIDTH   = 2,
    parameter int PIXEL_BITS         = 8,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   FRAME_START,
    input  logic                                   BUS_VALID,
    input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] BUS_DATA,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] OUT_DATA,
    output logic                                   OUT_SOF,
    output logic                                   OUT_EOL,
    output logic                                   OUT_EOF,
    output logic [$clog2(FIFO_DEPTH):0]            FIFO_LEVEL,
    output logic                                   OVERFLOW,
    output logic                                   PROTO_ERR,
    output logic                                   FRAME_DONE
);
    localparam int c_CHUNKS  = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int c_DW      = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int c_CHUNK_W = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    localparam int c_ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = c_DW + 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CHUNK_W-1:0] r_chunk_cnt;
    logic [c_ROW_W-1:0]   r_row_cnt;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_LVL_W-1:0]   w_level_next;
    logic                 r_overflow;
    logic                 r_proto_err;
    logic                 r_frame_done;
    logic                 w_drain_done;
    logic [c_ENTRY_W-1:0] w_head;

    wire w_start      = (r_state == S_IDLE) && FRAME_START;
    wire w_capture    = (r_state == S_CAPTURE) && BUS_VALID;
    wire w_full       = (r_level == c_LVL_W'(FIFO_DEPTH));
    wire w_pop        = OUT_VALID && OUT_READY;
    wire w_push       = w_capture && (!w_full || w_pop);
    wire w_last_chunk = (r_chunk_cnt == c_CHUNK_W'(c_CHUNKS - 1));
    wire w_last_row   = (r_row_cnt == c_ROW_W'(PIXEL_ARRAY_HEIGHT - 1));
    wire w_sof        = (r_chunk_cnt == '0) && (r_row_cnt == '0);
    wire w_eof        = w_last_chunk && w_last_row;
    wire w_proto_hit  = (FRAME_START && (r_state != S_IDLE)) ||
                        (BUS_VALID && (r_state != S_CAPTURE));

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_LVL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE:    if (FRAME_START) w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_capture && w_eof) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (w_level_next == '0) begin
                    w_state_next = S_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Counters advance on every captured word, dropped or not, to keep framing aligned
    always_ff @(posedge CLK) begin
        if (!RESET || w_start) begin
            r_chunk_cnt <= '0;
            r_row_cnt   <= '0;
        end else if (w_capture) begin
            if (w_last_chunk) begin
                r_chunk_cnt <= '0;
                r_row_cnt   <= w_last_row ? '0 : r_row_cnt + c_ROW_W'(1);
            end else begin
                r_chunk_cnt <= r_chunk_cnt + c_CHUNK_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_level <= w_level_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_sof, w_last_chunk, w_eof, BUS_DATA};
        end
    end

    // Arming a frame clears the sticky flags; a same-cycle violation still sets them
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_overflow   <= 1'b0;
            r_proto_err  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_overflow   <= (r_overflow && !w_start) || (w_capture && !w_push);
            r_proto_err  <= (r_proto_err && !w_start) || w_proto_hit;
            r_frame_done <= w_drain_done;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign OUT_VALID  = (r_level != '0);
    assign {OUT_SOF, OUT_EOL, OUT_EOF, OUT_DATA} = OUT_VALID ? w_head : '0;
    assign FIFO_LEVEL = r_level;
    assign OVERFLOW   = r_overflow;
    assign PROTO_ERR  = r_proto_err;
    assign FRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_collector
// Purpose  : Self-checking bench for pixel_stream_collector (vector table,
//            corner-case sequences and a randomized run against a queue model).
// Revision : 1.0
// ============================================================================
module tb_pixel_stream_collector;
    localparam int CHUNKS = 2;
    localparam int WORDS  = 8;
    localparam int DEPTH  = 8;

    logic        CLK = 1'b0;
    logic        RESET, FRAME_START, BUS_VALID, OUT_READY;
    logic [15:0] BUS_DATA;

    logic        a_valid, a_sof, a_eol, a_eof, a_ovf, a_perr, a_done;
    logic [15:0] a_data;
    logic [3:0]  a_level;
    logic        b_valid, b_sof, b_eol, b_eof, b_ovf, b_perr, b_done;
    logic [15:0] b_data;
    logic [3:0]  b_level;

    always #5 CLK = ~CLK;

    pixel_stream_collector u_dut (
        .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .BUS_VALID(BUS_VALID),
        .BUS_DATA(BUS_DATA), .OUT_VALID(a_valid), .OUT_READY(OUT_READY), .OUT_DATA(a_data),
        .OUT_SOF(a_sof), .OUT_EOL(a_eol), .OUT_EOF(a_eof), .FIFO_LEVEL(a_level),
        .OVERFLOW(a_ovf), .PROTO_ERR(a_perr), .FRAME_DONE(a_done)
    );

    // Taller frame (16 words) so the FIFO can fill and overflow within one frame
    pixel_stream_collector #(.PIXEL_ARRAY_HEIGHT(8)) u_dut_tall (
        .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .BUS_VALID(BUS_VALID),
        .BUS_DATA(BUS_DATA), .OUT_VALID(b_valid), .OUT_READY(OUT_READY), .OUT_DATA(b_data),
        .OUT_SOF(b_sof), .OUT_EOL(b_eol), .OUT_EOF(b_eof), .FIFO_LEVEL(b_level),
        .OVERFLOW(b_ovf), .PROTO_ERR(b_perr), .FRAME_DONE(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame position as a single word index, FIFO as a queue
    typedef struct packed { logic [15:0] data; logic sof, eol, eof; } word_t;
    word_t m_q[$];
    int    m_mode;
    int    m_pos;
    bit    m_ovf, m_perr, m_done;

    task automatic model_step(bit rst_n, bit fs, bit bv, logic [15:0] d, bit rdy);
        word_t w;
        bit    pop;
        if (!rst_n) begin
            m_q.delete();
            m_mode = 0; m_pos = 0; m_ovf = 0; m_perr = 0; m_done = 0;
            return;
        end
        pop    = (m_q.size() != 0) && rdy;
        m_done = 0;
        if (m_mode == 0 && fs) begin m_ovf = 0; m_perr = 0; end
        if ((fs && m_mode != 0) || (bv && m_mode != 1)) m_perr = 1;
        if (pop) void'(m_q.pop_front());
        case (m_mode)
            0: if (fs) begin m_mode = 1; m_pos = 0; end
            1: if (bv) begin
                w.data = d;
                w.sof  = (m_pos == 0);
                w.eol  = (m_pos % CHUNKS == CHUNKS - 1);
                w.eof  = (m_pos == WORDS - 1);
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
                m_pos++;
                if (m_pos == WORDS) m_mode = 2;
            end
            default: if (m_q.size() == 0) begin m_mode = 0; m_done = 1; end
        endcase
    endtask

    task automatic model_compare();
        word_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        check("m_valid", a_valid, m_q.size() != 0);
        check("m_data",  a_data,  h.data);
        check("m_tags",  {a_sof, a_eol, a_eof}, {h.sof, h.eol, h.eof});
        check("m_level", a_level, m_q.size());
        check("m_flags", {a_ovf, a_perr, a_done}, {m_ovf, m_perr, m_done});
    endtask

    logic [15:0] rx[$];

    task automatic step(bit rst_n, bit fs, bit bv, logic [15:0] d, bit rdy);
        RESET = rst_n; FRAME_START = fs; BUS_VALID = bv; BUS_DATA = d; OUT_READY = rdy;
        if (a_valid === 1'b1 && rdy) rx.push_back(a_data);
        @(posedge CLK);
        model_step(rst_n, fs, bv, d, rdy);
        #1;
        model_compare();
    endtask

    typedef struct {
        bit rst_n, fs, bv; logic [15:0] d; bit rdy;
        bit ev; logic [15:0] ed; bit es, el, ef; logic [3:0] lvl; bit eovf, eperr, edone;
    } vec_t;

    function automatic vec_t mk(bit rst_n, bit fs, bit bv, logic [15:0] d, bit rdy, bit ev,
                                logic [15:0] ed, bit es, bit el, bit ef, logic [3:0] lvl,
                                bit eovf, bit eperr, bit edone);
        vec_t v;
        v.rst_n = rst_n; v.fs = fs; v.bv = bv; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.ef = ef; v.lvl = lvl;
        v.eovf = eovf; v.eperr = eperr; v.edone = edone;
        return v;
    endfunction

    vec_t        tbl[13];
    int          k;
    bit          got_done, pend, rdy_t, bv_t;
    logic [15:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; FRAME_START = 1'b0; BUS_VALID = 1'b0; BUS_DATA = '0; OUT_READY = 1'b0;

        // Full frame with OUT_READY held high: each word surfaces the cycle after it is pushed
        tbl[0] = mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tbl[i+1] = mk(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b1, 1'b1, 16'(i * 257),
                          i == 1, i % 2 == 0, i == 8, 4'd1, 1'b0, 1'b0, 1'b0);
        end
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst_n, tbl[i].fs, tbl[i].bv, tbl[i].d, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
            check($sformatf("tbl%0d_data", i), a_data, tbl[i].ed);
            check($sformatf("tbl%0d_tags", i), {a_sof, a_eol, a_eof}, {tbl[i].es, tbl[i].el, tbl[i].ef});
            check($sformatf("tbl%0d_level", i), a_level, tbl[i].lvl);
            check($sformatf("tbl%0d_flags", i), {a_ovf, a_perr, a_done},
                  {tbl[i].eovf, tbl[i].eperr, tbl[i].edone});
        end

        // Overflow on the tall instance: 9 words with no reads
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b0);
        check("ovf_level", b_level, 8);
        check("ovf_flag", b_ovf, 1);
        check("ovf_head", b_data, 16'h0101);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", b_data, i * 257);
            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        end
        check("ovf_9th_absent", {b_valid, b_level}, 0);
        for (int i = 10; i <= 16; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("ovf_tall_done", b_done, 1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("ovf_sticky", b_ovf, 1);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check("ovf_cleared", b_ovf, 0);

        // Full FIFO with simultaneous push and pop
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b0);
        check("full_level", b_level, 8);
        step(1'b1, 1'b0, 1'b1, 16'h0909, 1'b1);
        check("full_pp_level", b_level, 8);
        check("full_pp_ovf", b_ovf, 0);
        check("full_pp_head", b_data, 16'h0202);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("full_pp_kept", {b_level, b_data}, {4'd1, 16'h0909});

        // OUT_READY toggling every cycle during a frame
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        rx.delete();
        k = 1; got_done = 0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            rdy_t = (c % 2 == 0);
            bv_t  = (k <= 8);
            pend  = (a_valid === 1'b1) && !rdy_t;
            held  = a_data;
            step(1'b1, 1'b0, bv_t, bv_t ? 16'(k * 257) : 16'h0, rdy_t);
            if (bv_t) k++;
            if (pend) check("stall_hold", a_data, held);
            if (a_done === 1'b1) got_done = 1;
        end
        check("stall_done", got_done, 1);
        check("stall_count", rx.size(), 8);
        for (int i = 0; i < rx.size() && i < 8; i++) check("stall_word", rx[i], (i + 1) * 257);

        // Protocol errors: BUS_VALID in IDLE, FRAME_START mid-capture
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'hdead, 1'b0);
        check("perr_idle", {a_perr, a_level}, {1'b1, 4'd0});
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check("perr_clear", a_perr, 0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check("perr_start", {a_perr, a_level}, {1'b1, 4'd3});
        for (int i = 4; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b0);
        check("perr_level", a_level, 8);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("perr_last", {a_data, a_sof, a_eol, a_eof}, {16'h0808, 3'b011});

        // Reset mid-frame
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 257), 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("rst_mid", {a_valid, a_level}, 0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check("rst_restart", a_perr, 0);
        step(1'b1, 1'b0, 1'b1, 16'h4242, 1'b0);
        check("rst_first", {a_sof, a_data, a_level}, {1'b1, 16'h4242, 4'd1});

        // Randomized traffic against the model
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 99) < 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
